// File: rtl/intf_lane_monitor.sv
// ============================================================================
// intf_lane_monitor
// ----------------------------------------------------------------------------
// Purpose:
//   Watches an array of 1-bit lanes (one bit per interface instance) and turns
//   every lane transition into an event {lane index, new value}. The events go
//   through a small show-ahead FIFO with a valid/ready handshake. A checker can
//   follow lane activity this way instead of polling every interface.
//
// Optional feature (macro INTF_LANE_MONITOR_SYNC_EN):
//   When the macro is defined, two flop stages are added in front of the
//   sample register. They resynchronise lanes driven from an asynchronous
//   domain. Event latency grows by two cycles. Nothing else changes.
//   When the macro is not defined, lane_in goes straight into the sample
//   register.
//
// Parameters:
//   N      number of lanes (2..64)
//   DEPTH  event FIFO depth (power of two, >= 2)
//   IW     lane index width, derived from N
//
// Ports:
//   clk       in   clock, all state updates on posedge
//   rst_n     in   asynchronous active-low reset
//   lane_in   in   [N-1:0] lane bits
//   ev_valid  out  event available at the FIFO head
//   ev_ready  in   consumer accepts the head event
//   ev_idx    out  [IW-1:0] lane index of the head event
//   ev_val    out  new lane value of the head event
//   ev_count  out  [$clog2(DEPTH):0] FIFO occupancy
//   stall     out  a change is pending but the FIFO is full and not popping
// ============================================================================
module intf_lane_monitor #(
    parameter int N     = 6,
    parameter int DEPTH = 4,
    localparam int IW   = $clog2(N),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  lane_in,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [IW-1:0] ev_idx,
    output logic          ev_val,
    output logic [CW-1:0] ev_count,
    output logic          stall
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  w_sampleSrc;
    logic [N-1:0]  r_smp;
    logic [N-1:0]  r_reported;
    logic [N-1:0]  w_diff;
    logic [IW-1:0] w_pushIdx;
    logic          w_pushVal;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    logic [IW:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

`ifdef INTF_LANE_MONITOR_SYNC_EN
    logic [N-1:0]  r_sync1;
    logic [N-1:0]  r_sync2;

    // Two-flop resynchroniser in front of the sample register, for lanes
    // that come from an unrelated clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= lane_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sampleSrc = r_sync2;
`else
    assign w_sampleSrc = lane_in;
`endif

    // Sample register. Every lane is compared against its last reported value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp <= '0;
        end else begin
            r_smp <= w_sampleSrc;
        end
    end

    // A lane that flips back before it is pushed drops out of diff on its
    // own. Short glitches therefore produce no event.
    assign w_diff = r_smp ^ r_reported;

    // Fixed-priority select of the lowest pending lane. Scanning downward
    // lets the lowest set bit overwrite the earlier ones.
    always_comb begin
        w_pushIdx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_pushIdx = IW'(i);
            end
        end
    end

    assign w_pushVal = r_smp[w_pushIdx];

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = ev_valid && ev_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push = (w_diff != '0) && (!w_full || w_pop);

    // Once a change is queued, its value becomes the lane's reported state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reported <= '0;
        end else if (w_push) begin
            r_reported[w_pushIdx] <= w_pushVal;
        end
    end

    // FIFO storage. The entries are reset so that the show-ahead head reads
    // as zero while the FIFO is empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= {w_pushIdx, w_pushVal};
        end
    end

    // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
    // pointers wrap naturally. A push and a pop in the same cycle leave the
    // count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign ev_valid = (r_count != '0);
    assign ev_idx   = r_mem[r_rptr][IW:1];
    assign ev_val   = r_mem[r_rptr][0];
    assign ev_count = r_count;
    assign stall    = (w_diff != '0) && w_full && !w_pop;

endmodule

// File: tb/tb_intf_lane_monitor.sv
// ============================================================================
// tb_intf_lane_monitor
// ----------------------------------------------------------------------------
// Directed bench for intf_lane_monitor (N=6, DEPTH=4). Each stimulus step
// queues its hand-computed events. A monitor process pops and compares an
// entry whenever the DUT hands over an event. Occupancy, stall, reset and
// latency are checked directly from the main sequence.
// ============================================================================
module tb_intf_lane_monitor;

    localparam int N     = 6;
    localparam int DEPTH = 4;
    localparam int IW    = 3;
    localparam int CW    = 3;
`ifdef INTF_LANE_MONITOR_SYNC_EN
    localparam int SYNC  = 2;
`else
    localparam int SYNC  = 0;
`endif

    logic          clk;
    logic          rstN;
    logic [N-1:0]  laneIn;
    logic          evReady;
    logic          evValid;
    logic [IW-1:0] evIdx;
    logic          evVal;
    logic [CW-1:0] evCount;
    logic          stall;

    logic [IW:0]   expQ [$];
    int            numVectors;
    int            numMiscompares;

    intf_lane_monitor #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .lane_in  (laneIn),
        .ev_valid (evValid),
        .ev_ready (evReady),
        .ev_idx   (evIdx),
        .ev_val   (evVal),
        .ev_count (evCount),
        .stall    (stall)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: an accepted event must match the oldest expected one.
    always @(negedge clk) begin
        if (rstN && evValid && evReady) begin
            numVectors++;
            if (expQ.size() == 0) begin
                numMiscompares++;
                $display("[TB] FAIL event_unexpected: got idx=%0d val=%0d, required none", evIdx, evVal);
            end else begin
                if ({evIdx, evVal} !== expQ[0]) begin
                    numMiscompares++;
                    $display("[TB] FAIL event: got idx=%0d val=%0d, required idx=%0d val=%0d",
                             evIdx, evVal, expQ[0][IW:1], expQ[0][0]);
                end
                void'(expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [N-1:0] lanes, input logic ready);
        @(posedge clk);
        #1;
        laneIn  = lanes;
        evReady = ready;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        numVectors++;
        if (actual !== required) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic expectEvent(input int idx, input logic val);
        expQ.push_back({IW'(idx), val});
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait until every expected event has been consumed and the FIFO is empty.
    task automatic waitIdle(input string name);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (!(expQ.size() == 0 && evCount == '0) && cyc < 60);
        checkOutput({name, "_drained"}, (expQ.size() == 0 && evCount == '0) ? 1 : 0, 1);
    endtask

    initial begin
        numVectors     = 0;
        numMiscompares = 0;
        rstN           = 1'b0;
        laneIn         = '0;
        evReady        = 1'b1;

        // Reset state
        #12;
        checkOutput("rst_ev_valid", evValid, 0);
        checkOutput("rst_ev_count", evCount, 0);
        checkOutput("rst_ev_idx",   evIdx,   0);
        checkOutput("rst_ev_val",   evVal,   0);
        checkOutput("rst_stall",    stall,   0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        waitCycles(2);

        // Three lanes rise together. Expect three back-to-back events and
        // check the exact cycle on which ev_valid rises.
        expectEvent(0, 1'b1);
        expectEvent(2, 1'b1);
        expectEvent(4, 1'b1);
        applyStimulus(6'b010101, 1'b1);
        for (int m = 0; m <= 5 + SYNC; m++) begin
            @(negedge clk);
            checkOutput($sformatf("latency_m%0d", m), evValid,
                        (m >= 2 + SYNC && m <= 4 + SYNC) ? 1 : 0);
        end
        waitIdle("first_burst");

        // Return everything to 0 so that all six lanes can rise next.
        expectEvent(0, 1'b0);
        expectEvent(2, 1'b0);
        expectEvent(4, 1'b0);
        applyStimulus(6'b000000, 1'b1);
        waitIdle("all_low");

        // Consumer stalled, six lanes rise. The FIFO fills and stall is raised.
        for (int i = 0; i < N; i++) expectEvent(i, 1'b1);
        applyStimulus(6'b111111, 1'b0);
        waitCycles(SYNC + 8);
        checkOutput("full_count", evCount, 4);
        checkOutput("full_stall", stall, 1);
        checkOutput("full_head_idx", evIdx, 0);
        checkOutput("full_head_val", evVal, 1);

        // Lane 3 (reported 1) glitches low for a single cycle while full.
        // No event may appear for it.
        applyStimulus(6'b110111, 1'b0);
        applyStimulus(6'b111111, 1'b0);
        waitCycles(SYNC + 4);
        checkOutput("glitch_count", evCount, 4);
        checkOutput("glitch_stall", stall, 1);
        checkOutput("glitch_head_idx", evIdx, 0);

        // Release the consumer: lanes 0..5 in order, nothing lost.
        applyStimulus(6'b111111, 1'b1);
        waitIdle("drain_six");
        waitCycles(4);
        checkOutput("drained_stall", stall, 0);
        checkOutput("drained_valid", evValid, 0);

        // Fill with lanes 0..3 falling, then lane 5 falls while full.
        for (int i = 0; i < 4; i++) expectEvent(i, 1'b0);
        applyStimulus(6'b110000, 1'b0);
        waitCycles(SYNC + 7);
        checkOutput("fill4_count", evCount, 4);
        checkOutput("fill4_stall", stall, 0);
        expectEvent(5, 1'b0);
        applyStimulus(6'b010000, 1'b0);
        waitCycles(SYNC + 2);
        checkOutput("lane5_stall", stall, 1);
        applyStimulus(6'b010000, 1'b1);
        @(negedge clk);
        checkOutput("pushpop_stall", stall, 0);
        @(negedge clk);
        checkOutput("pushpop_count", evCount, 4);
        checkOutput("pushpop_head_idx", evIdx, 1);
        waitIdle("drain_lane5");

        // Mid-stream reset with three queued events. They are discarded.
        applyStimulus(6'b010111, 1'b0);
        waitCycles(SYNC + 6);
        checkOutput("pre_reset_count", evCount, 3);
        #2;
        rstN   = 1'b0;
        laneIn = 6'b100000;
        #1;
        checkOutput("async_rst_valid", evValid, 0);
        checkOutput("async_rst_count", evCount, 0);
        checkOutput("async_rst_idx",   evIdx,   0);
        checkOutput("async_rst_val",   evVal,   0);
        checkOutput("async_rst_stall", stall,   0);
        @(posedge clk);
        @(posedge clk);
        #1;
        expectEvent(5, 1'b1);
        evReady = 1'b1;
        rstN    = 1'b1;
        waitIdle("post_reset");
        waitCycles(6);
        checkOutput("final_count", evCount, 0);
        checkOutput("final_queue", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
